// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM controller: serialises whole
// transactions, holds one controller enable per transaction, returns done/rdata/stall.
module sram_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        stall0,
  output logic        stall1,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_pause
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              ptr_reg, ptr_next;
  logic              wr_en_reg, wr_en_next;
  logic              rd_en_reg, rd_en_next;
  logic [31:0]       addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [1:0]        done_reg, done_next;
  logic [1:0][31:0]  rdata_reg, rdata_next;
  logic              winner;
  logic              win_we;
  logic [31:0]       win_addr;
  logic [31:0]       win_wdata;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    if (req0 && req1) begin
      winner = (PRIORITY_MODE != 0) ? 1'b0 : ptr_reg;
    end else begin
      winner = req1;
    end
    win_we    = winner ? we1    : we0;
    win_addr  = winner ? addr1  : addr0;
    win_wdata = winner ? wdata1 : wdata0;
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    wr_en_next = wr_en_reg;
    rd_en_next = rd_en_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    done_next  = 2'b00;
    rdata_next = rdata_reg;

    case (state_reg)
      IDLE: begin
        if (req0 || req1) begin
          owner_next = winner;
          ptr_next   = ~winner;
          wr_en_next = win_we;
          rd_en_next = ~win_we;
          addr_next  = win_addr;
          wdata_next = win_wdata;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        // Completion cycle: enable high with pause low.
        if (!mem_pause) begin
          if (rd_en_reg) begin
            rdata_next[owner_reg] = mem_rdata;
          end
          wr_en_next           = 1'b0;
          rd_en_next           = 1'b0;
          done_next[owner_reg] = 1'b1;
          state_next           = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
      ptr_reg   <= 1'b0;
      wr_en_reg <= 1'b0;
      rd_en_reg <= 1'b0;
      addr_reg  <= 32'h0;
      wdata_reg <= 32'h0;
      done_reg  <= 2'b00;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      wr_en_reg <= wr_en_next;
      rd_en_reg <= rd_en_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      done_reg  <= done_next;
      rdata_reg <= rdata_next;
    end
  end

  assign done0     = done_reg[0];
  assign done1     = done_reg[1];
  assign rdata0    = rdata_reg[0];
  assign rdata1    = rdata_reg[1];
  assign stall0    = req0 & ~done_reg[0];
  assign stall1    = req1 & ~done_reg[1];
  assign mem_wr_en = wr_en_reg;
  assign mem_rd_en = rd_en_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: transaction-level reference model feeds a
// queue of expected completions; a negedge monitor checks bus activity and done pulses.
`timescale 1ns/1ps
module tb_sram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        done0, done1, stall0, stall1;
  logic [31:0] rdata0, rdata1;
  logic        mem_wr_en, mem_rd_en, mem_pause;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // fixed-priority instance, controller with zero latency
  logic        p_req0, p_req1, p_we0, p_we1;
  logic [31:0] p_addr0, p_addr1, p_wdata0, p_wdata1;
  logic        p_done0, p_done1, p_stall0, p_stall1;
  logic [31:0] p_rdata0, p_rdata1;
  logic        p_mem_wr_en, p_mem_rd_en;
  logic [31:0] p_mem_addr, p_mem_wdata;
  logic        p_mem_pause;
  logic [31:0] p_mem_rdata;
  assign p_mem_pause = 1'b0;
  assign p_mem_rdata = 32'h0;

  sram_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
    .stall0(stall0), .stall1(stall1),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_pause(mem_pause)
  );

  sram_arbiter #(.PRIORITY_MODE(1)) dut_pri (
    .clk(clk), .rst(rst),
    .req0(p_req0), .we0(p_we0), .addr0(p_addr0), .wdata0(p_wdata0),
    .req1(p_req1), .we1(p_we1), .addr1(p_addr1), .wdata1(p_wdata1),
    .done0(p_done0), .done1(p_done1), .rdata0(p_rdata0), .rdata1(p_rdata1),
    .stall0(p_stall0), .stall1(p_stall1),
    .mem_wr_en(p_mem_wr_en), .mem_rd_en(p_mem_rd_en),
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .mem_pause(p_mem_pause)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'd128) return 32'h1234_5678;
    return 32'hC0DE_0000 | {24'h0, i};
  endfunction

  // Controller model: pause held for t_lat cycles of an enable, write commits at completion.
  int          t_lat = 5;
  int          ctl_cnt = 0;
  logic [31:0] sram [256];
  bit          sram_valid [256];
  assign mem_pause = (mem_wr_en || mem_rd_en) && (ctl_cnt < t_lat);
  assign mem_rdata = sram_valid[mem_addr[9:2]] ? sram[mem_addr[9:2]] : init_word(mem_addr[9:2]);
  always @(posedge clk) begin
    if (rst || !(mem_wr_en || mem_rd_en)) ctl_cnt <= 0;
    else ctl_cnt <= ctl_cnt + 1;
    if (!rst && mem_wr_en && !mem_pause) begin
      sram[mem_addr[9:2]]       <= mem_wdata;
      sram_valid[mem_addr[9:2]] <= 1'b1;
    end
  end

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          done_cyc;
    int          t;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          ptr_m = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] shadow_rd [2];
  bit          aborting = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("both_enables", 32'(mem_wr_en & mem_rd_en), 32'h0);
      check("stall0", 32'(stall0), 32'(req0 & ~done0));
      check("stall1", 32'(stall1), 32'(req1 & ~done1));
      if (done0 || done1) check("enable_in_done", 32'(mem_wr_en | mem_rd_en), 32'h0);
      if (aborting) begin
        check("abort_no_done", 32'(done0 | done1), 32'h0);
      end else begin
        if (mem_wr_en || mem_rd_en) begin
          if (sbq.size() == 0) begin
            check("spurious_enable", 32'(mem_wr_en | mem_rd_en), 32'h0);
          end else begin
            mon_e = sbq[0];
            check("wr_en", 32'(mem_wr_en), 32'(mon_e.we));
            check("rd_en", 32'(mem_rd_en), 32'(!mon_e.we));
            check("mem_addr", mem_addr, mon_e.addr);
            if (mon_e.we) check("mem_wdata", mem_wdata, mon_e.wdata);
            check("enable_early", 32'(cyc >= mon_e.done_cyc - 1 - mon_e.t), 32'h1);
          end
        end
        if (done0 || done1) begin
          if (sbq.size() == 0) begin
            check("spurious_done", 32'({done1, done0}), 32'h0);
          end else begin
            mon_e = sbq.pop_front();
            $display("txn port%0d we=%0d addr=%h done at cycle %0d rdata0=%h rdata1=%h",
                     mon_e.port, mon_e.we, mon_e.addr, cyc, rdata0, rdata1);
            check("done_port", 32'(done1), 32'(mon_e.port == 1));
            check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
            check("rdata0", rdata0, mon_e.rd0);
            check("rdata1", rdata1, mon_e.rd1);
          end
        end
      end
    end
  end

  // Issue one or two simultaneous requests; the model orders them and predicts completions.
  task automatic run_round(input bit r0, input bit r1, input logic w0, input logic w1,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input int t);
    int   g, first, n, p, budget;
    bit   dn0, dn1;
    exp_t e;
    t_lat = t;
    @(posedge clk); #1;
    we0 = w0; addr0 = a0; wdata0 = d0;
    we1 = w1; addr1 = a1; wdata1 = d1;
    req0 = r0; req1 = r1;
    g = cyc;
    first = (r0 && r1) ? ptr_m : (r1 ? 1 : 0);
    n = (r0 && r1) ? 2 : 1;
    for (int k = 0; k < n; k++) begin
      p = (k == 0) ? first : 1 - first;
      e.port     = p;
      e.we       = (p == 0) ? w0 : w1;
      e.addr     = (p == 0) ? a0 : a1;
      e.wdata    = (p == 0) ? d0 : d1;
      e.t        = t;
      e.done_cyc = g + t + 2;
      if (e.we) ref_mem[e.addr[9:2]] = e.wdata;
      else shadow_rd[p] = ref_mem[e.addr[9:2]];
      e.rd0 = shadow_rd[0];
      e.rd1 = shadow_rd[1];
      sbq.push_back(e);
      ptr_m = 1 - p;
      g = g + t + 3;
    end
    budget = 40;
    while ((req0 || req1) && budget > 0) begin
      @(negedge clk);
      dn0 = done0; dn1 = done1;
      @(posedge clk); #1;
      if (dn0) req0 = 1'b0;
      if (dn1) req1 = 1'b0;
      budget--;
    end
    check("round_complete", 32'(req0 | req1), 32'h0);
    if (req0 || req1) begin
      req0 = 1'b0; req1 = 1'b0;
      sbq.delete();
    end
  endtask

  initial begin
    int c0, pd0, pd1, ps1;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    p_req0 = 0; p_req1 = 0; p_we0 = 1; p_we1 = 1;
    p_addr0 = 32'h10; p_addr1 = 32'h20; p_wdata0 = 32'h1; p_wdata1 = 32'h2;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    shadow_rd[0] = 0; shadow_rd[1] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(mem_wr_en), 32'h0);
    check("rst_rd_en", 32'(mem_rd_en), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_done", 32'({done1, done0}), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_stall", 32'({stall1, stall0}), 32'h0);
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check("idle_enables", 32'({mem_wr_en, mem_rd_en}), 32'h0);
    end

    run_round(1, 0, 1, 0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF, 32'h0, 5);
    run_round(0, 1, 0, 0, 32'h0, 32'h0000_0200, 32'h0, 32'h0, 5);
    run_round(1, 1, 0, 1, 32'h0000_0104, 32'h0000_0008, 32'h0, 32'hCAFE_0001, 5);
    run_round(1, 1, 1, 0, 32'h0000_0008, 32'h0000_0008, 32'h5555_AAAA, 32'h0, 5);
    run_round(1, 0, 0, 0, 32'h0000_0200, 32'h0, 32'h0, 32'h0, 0);
    run_round(0, 1, 1, 0, 32'h0, 32'h0000_000C, 32'h0, 32'h7777_0000, 9);
    run_round(1, 1, 0, 0, 32'h0000_000C, 32'h0000_0104, 32'h0, 32'h0, 0);

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      run_round(sel[0], sel[1], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 15)) << 2, 32'($urandom_range(0, 15)) << 2,
                $urandom, $urandom, $urandom_range(0, 9));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    // Reset in the middle of a write: no done, enables drop, nothing committed.
    t_lat = 5;
    @(posedge clk); #1;
    aborting = 1'b1;
    we0 = 1; addr0 = 32'h0000_0040; wdata0 = 32'hBAD0_BAD0; req0 = 1;
    c0 = cyc;
    repeat (3) @(posedge clk);
    #1;
    check("abort_cycle", 32'(cyc), 32'(c0 + 3));
    rst = 1'b1; req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_enables", 32'({mem_wr_en, mem_rd_en}), 32'h0);
    check("abort_done", 32'({done1, done0}), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    aborting = 1'b0;
    ptr_m = 0;
    shadow_rd[0] = 0; shadow_rd[1] = 0;
    run_round(1, 0, 1, 0, 32'h0000_0044, 32'h0, 32'h0123_4567, 32'h0, 5);
    run_round(1, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0, 32'h0, 5);

    // Fixed priority: port 0 holding its request starves port 1.
    @(posedge clk); #1;
    p_req0 = 1; p_req1 = 1;
    pd0 = 0; pd1 = 0; ps1 = 0;
    repeat (40) begin
      @(negedge clk);
      pd0 += int'(p_done0);
      pd1 += int'(p_done1);
      ps1 += int'(p_stall1);
    end
    p_req0 = 0; p_req1 = 0;
    $display("priority mode: done0 count %0d done1 count %0d stall1 cycles %0d", pd0, pd1, ps1);
    check("pri_done0_count", 32'(pd0), 32'd13);
    check("pri_done1_count", 32'(pd1), 32'd0);
    check("pri_stall1", 32'(ps1), 32'd40);

    repeat (4) @(posedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
